// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared types and widths for the ALU scheduler
package alu_sched_pkg;
    localparam int RES_W = 16;
    localparam int OP_W  = 8;

    typedef enum logic [1:0] {IDLE, CALC, RESP} sched_state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            cin;
    } alu_req_t;
endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: per-requester request channels plus the shared tagged response channel
interface alu_sched_if
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0][OP_W-1:0] req_a;
    logic [NREQ-1:0][OP_W-1:0] req_b;
    logic [NREQ-1:0]           req_cin;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [IDW-1:0]            rsp_id;
    logic [RES_W-1:0]          rsp_data;
    logic                      busy;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/alu_sched_alu.sv
// alu: shared datapath, result = 2*A + 4*B + Cin, never exceeds 11 bits
module alu
    import alu_sched_pkg::*;
(
    input  alu_req_t         op_i,
    output logic [RES_W-1:0] res_o
);
    assign res_o = (RES_W'(op_i.a) << 1) + (RES_W'(op_i.b) << 2) + RES_W'(op_i.cin);
endmodule

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: picks the first pending request at or after ptr, wrapping around
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] gnt_idx_o,
    output logic         gnt_any_o
);
    logic [W-1:0] k;

    // Scan from the farthest offset down so the nearest requester at or after ptr wins
    always_comb begin
        gnt_idx_o = '0;
        k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = W'((int'(ptr_i) + i) % N);
            if (req_i[k]) gnt_idx_o = k;
        end
    end

    assign gnt_any_o = |req_i;
endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one ALU among NREQ requesters
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_sched_if.slave io
);
    sched_state_t     state_q, state_d;
    alu_req_t         op_q, op_d;
    logic [IDW-1:0]   gid_q, gid_d, ptr_q, ptr_d, rsp_id_q, rsp_id_d, gnt_idx;
    logic [RES_W-1:0] rsp_data_q, rsp_data_d, alu_res;
    logic             gnt_any;

    rr_arbiter #(.N(NREQ), .W(IDW)) u_arb (
        .req_i     (io.req_valid),
        .ptr_i     (ptr_q),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    alu u_alu (
        .op_i  (op_q),
        .res_o (alu_res)
    );

    assign io.req_ready = (rst_n && state_q == IDLE && gnt_any) ? NREQ'(1) << gnt_idx : '0;
    assign io.rsp_valid = state_q == RESP;
    assign io.busy      = state_q != IDLE;
    assign io.rsp_id    = rsp_id_q;
    assign io.rsp_data  = rsp_data_q;

    // Accept in IDLE, register the ALU result in CALC, hold the response until taken
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        gid_d      = gid_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: if (gnt_any) begin
                state_d  = CALC;
                op_d.a   = io.req_a[gnt_idx];
                op_d.b   = io.req_b[gnt_idx];
                op_d.cin = io.req_cin[gnt_idx];
                gid_d    = gnt_idx;
            end
            CALC: begin
                state_d    = RESP;
                rsp_data_d = alu_res;
                rsp_id_d   = gid_q;
            end
            RESP: if (io.rsp_ready) begin
                state_d = IDLE;
                ptr_d   = (int'(gid_q) == NREQ - 1) ? '0 : gid_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            gid_q      <= '0;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            gid_q      <= gid_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end
endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one `ALU` datapath instance (result = 2·A + 4·B + Cin, 16 bits) between NREQ requesters. Each requester presents operands on a valid/ready request channel. The scheduler grants one requester at a time, latches its operands, and registers the datapath result. It returns the result on a single shared, tagged valid/ready response channel.

## Interface
- `NREQ`, default 4: number of requesters; legal values are 2..16.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID tag.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req_valid` input, [NREQ]: request pending, one bit per requester.
- `req_ready` output, [NREQ]: request accepted; at most one bit high in any cycle.
- `req_a` input, [NREQ][8]: operand A per requester.
- `req_b` input, [NREQ][8]: operand B per requester.
- `req_cin` input, [NREQ]: carry-in per requester.
- `rsp_valid` output, 1 bit: a result is available.
- `rsp_ready` input, 1 bit: the consumer accepts the result.
- `rsp_id` output, IDW bits: index of the requester that owns `rsp_data`.
- `rsp_data` output, 16 bits: result {Sum2, Sum1}.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- FSM has three states: IDLE, CALC, RESP.
- **IDLE**
  - If any `req_valid` is high, the arbiter picks grant index g: the first valid requester at or after `rr_ptr`, searching with wrap-around from NREQ-1 to 0.
  - `req_ready[g]` is driven high combinationally in the same cycle; all other `req_ready` bits stay 0.
  - On the clock edge: latch `req_a[g]`, `req_b[g]`, `req_cin[g]` and g, then go to CALC.
  - If no `req_valid` is high, stay in IDLE.
- **CALC**
  - The ALU computes from the latched operands.
  - On the edge: register the full 16-bit sum into `rsp_data`, set `rsp_id` = g, go to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - When `rsp_ready` is 1 on an edge: set `rr_ptr` = (g+1) mod NREQ and go to IDLE.
  - Otherwise hold; `rsp_data` and `rsp_id` stay stable.
- **Arithmetic**
  - The result is the unsigned sum 2A + 4B + Cin. Maximum value is 1531 (0x05FB); bits [15:11] are always 0.
  - No saturation and no truncation.
- `req_ready` is 0 in CALC and RESP, so no new request is accepted until the response completes.
- A requester that drops `req_valid` while not granted is simply skipped. Once granted, its request is consumed.
- `req_valid` is sampled only in IDLE. Operand changes after acceptance have no effect.

## Timing
- **Reset values** (all outputs 0):
  - state = IDLE, `rr_ptr` = 0.
  - `req_ready` = 0 while `rst_n` is low; `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `busy` = 0.
- **Latency:** request accepted at edge k, then `rsp_valid` rises after edge k+1 and is visible during cycle k+2.
- **Throughput:** at most one transaction per 3 cycles when `rsp_ready` is held high.
- **Simultaneous requests:** resolved by `rr_ptr`. Requesters with equal load are never starved; the worst-case wait is NREQ transactions.
- **Response backpressure:** while `rsp_ready` is 0, the block stalls indefinitely in RESP. `rsp_valid` must not drop and its data must not change.
- **Reset mid-transaction:** asserting `rst_n` low in any state immediately forces the reset values. The latched transaction is discarded and no response is produced.
- **`rr_ptr` update:** advances only on response completion, never on acceptance alone.

## Structure
- Package `alu_sched_pkg`:
  - `sched_state_t` enum {IDLE, CALC, RESP}.
  - `RES_W` = 16 and `OP_W` = 8.
  - `alu_req_t` struct {a, b, cin}.
- Sub-module `rr_arbiter`, parameterised by N.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `gnt_idx`, `gnt_any`.
  - Purely combinational.
- Top level `alu_sched`: FSM, operand/ID registers, result register, `rr_ptr`, and one `ALU` instance.

## Test plan
- **Max result:** requester 0 sends A=0xFF, B=0xFF, Cin=1 → `rsp_valid` in cycle k+2 with `rsp_data`=0x05FB, `rsp_id`=0.
- **Basic case:** requester 2 sends A=3, B=5, Cin=0 → `rsp_data`=0x001A, `rsp_id`=2, `req_ready` pulses only bit 2.
- **Round robin:** all four `req_valid` held high, `rsp_ready`=1, after reset → grant order 0,1,2,3,0,1; one response every 3 cycles.
- **Backpressure:** `rsp_ready` held 0 for 5 cycles in RESP → `rsp_valid`, `rsp_data`, `rsp_id` stable; all `req_ready`=0; `busy`=1. Completion occurs on the first edge after `rsp_ready` rises.
- **Reset in CALC:** `rst_n` pulsed low during CALC → all outputs 0 immediately. No response follows, and the next grant starts from requester 0.
- **Skipped requester:** `req_valid`=4'b1010 with `rr_ptr`=2 → requester 3 is granted first, then requester 1.
